// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one N-bit adder between REQS requesters.
// The winner's operands are captured, summed on the next cycle, and the
// result is returned with the requester index over a valid/ready channel.
module adder_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned REQS = 4,
  localparam int unsigned IDW = $clog2(REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REQS-1:0]     req,
  input  logic [REQS*N-1:0]   a_in,
  input  logic [REQS*N-1:0]   b_in,
  input  logic [REQS-1:0]     cin_in,
  output logic [REQS-1:0]     gnt,
  output logic                busy,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [N-1:0]        rsp_sum,
  output logic                rsp_cout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]  win_q, win_nxt;
  logic [N-1:0]    op_a, op_a_nxt;
  logic [N-1:0]    op_b, op_b_nxt;
  logic            op_cin, op_cin_nxt;
  logic [REQS-1:0] gnt_nxt;
  logic            busy_nxt;
  logic            rsp_valid_nxt;
  logic [IDW-1:0]  rsp_id_nxt;
  logic [N-1:0]    rsp_sum_nxt;
  logic            rsp_cout_nxt;

  logic            found_c;
  logic [IDW-1:0]  win_c;
  int unsigned     idx;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic            sel_cin;
  logic [N:0]      sum_full;

  // Round-robin pick: first set request bit at or after rr_ptr, wrapping.
  always_comb begin
    found_c = 1'b0;
    win_c   = rr_ptr;
    idx     = 0;
    for (int unsigned k = 0; k < REQS; k++) begin
      idx = (32'(rr_ptr) + k) % REQS;
      if (!found_c && req[IDW'(idx)]) begin
        found_c = 1'b1;
        win_c   = IDW'(idx);
      end
    end
  end

  // Select the winning requester's operand slice.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < int'(REQS); i++) begin
      if (win_c == IDW'(i)) begin
        sel_a   = a_in[i*N +: N];
        sel_b   = b_in[i*N +: N];
        sel_cin = cin_in[i];
      end
    end
  end

  // Shared adder on the captured operands.
  assign sum_full = {1'b0, op_a} + {1'b0, op_b} + (N+1)'(op_cin);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    win_nxt       = win_q;
    op_a_nxt      = op_a;
    op_b_nxt      = op_b;
    op_cin_nxt    = op_cin;
    gnt_nxt       = '0;
    busy_nxt      = busy;
    rsp_valid_nxt = rsp_valid;
    rsp_id_nxt    = rsp_id;
    rsp_sum_nxt   = rsp_sum;
    rsp_cout_nxt  = rsp_cout;
    case (state)
      IDLE: begin
        if (found_c) begin
          op_a_nxt   = sel_a;
          op_b_nxt   = sel_b;
          op_cin_nxt = sel_cin;
          win_nxt    = win_c;
          gnt_nxt    = REQS'(1) << win_c;
          busy_nxt   = 1'b1;
          state_nxt  = COMPUTE;
        end
      end
      COMPUTE: begin
        rsp_sum_nxt   = sum_full[N-1:0];
        rsp_cout_nxt  = sum_full[N];
        rsp_id_nxt    = win_q;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RESPOND;
      end
      RESPOND: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rr_ptr_nxt    = (win_q == IDW'(REQS-1)) ? '0 : win_q + IDW'(1);
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_q     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      win_q     <= win_nxt;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      op_cin    <= op_cin_nxt;
      gnt       <= gnt_nxt;
      busy      <= busy_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      rsp_sum   <= rsp_sum_nxt;
      rsp_cout  <= rsp_cout_nxt;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter (N=8, REQS=4).
module tb_adder_arbiter;

  localparam int unsigned N    = 8;
  localparam int unsigned REQS = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [REQS-1:0]   req;
  logic [REQS*N-1:0] a_in;
  logic [REQS*N-1:0] b_in;
  logic [REQS-1:0]   cin_in;
  logic [REQS-1:0]   gnt;
  logic              busy;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_cout;

  adder_arbiter #(.N(N), .REQS(REQS)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .cin_in(cin_in), .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;
  int          op_a [REQS];
  int          op_b [REQS];
  int          op_c [REQS];
  int          exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive the packed operand buses from the per-requester arrays.
  task automatic drive_ops();
    for (int i = 0; i < int'(REQS); i++) begin
      a_in[i*N +: N] = 8'(op_a[i]);
      b_in[i*N +: N] = 8'(op_b[i]);
      cin_in[i]      = 1'(op_c[i]);
    end
  endtask

  // Expected response word {id, cout, sum} for requester id's current operands.
  task automatic push_exp(input int id);
    int full;
    full = op_a[id] + op_b[id] + op_c[id];
    exp_q.push_back((id << 9) | (full & 9'h1ff));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string tag, input logic [REQS-1:0] exp_g);
    int cyc;
    cyc = 0;
    tick();
    while (gnt == '0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check(tag, 32'(gnt), 32'(exp_g));
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (busy && cyc < 20) begin
      tick();
      cyc++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic do_one(input int id, input int a, input int b, input int c);
    op_a[id] = a; op_b[id] = b; op_c[id] = c;
    drive_ops();
    push_exp(id);
    req = REQS'(1) << id;
    wait_gnt("single_gnt", REQS'(1) << id);
    req = '0;
    tick();
    wait_idle("single_idle");
  endtask

  // Scoreboard: pop and compare whenever a handshake is about to happen.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("rsp_id",   32'(rsp_id),   32'((e >> 9) & 3));
        check("rsp_cout", 32'(rsp_cout), 32'((e >> 8) & 1));
        check("rsp_sum",  32'(rsp_sum),  32'(e & 8'hff));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; rsp_ready = 1'b1;
    for (int i = 0; i < int'(REQS); i++) begin
      op_a[i] = 0; op_b[i] = 0; op_c[i] = 0;
    end
    drive_ops();
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_sum", 32'(rsp_sum), 32'd0);
    check("rst_cout", 32'(rsp_cout), 32'd0);
    reset = 1'b0;
    tick();

    // Single request with latency checks
    op_a[1] = 5; op_b[1] = 1; op_c[1] = 0;
    drive_ops();
    push_exp(1);
    req = 4'b0010;
    tick();
    check("lat_gnt", 32'(gnt), 32'b0010);
    check("lat_busy", 32'(busy), 32'd1);
    req = '0;
    tick();
    check("lat_valid", 32'(rsp_valid), 32'd1);
    check("lat_gnt_drop", 32'(gnt), 32'd0);
    tick();
    check("lat_valid_drop", 32'(rsp_valid), 32'd0);
    wait_idle("lat_idle");

    // Overflow / carry cases; rr_ptr ends at 0
    do_one(2, 254, 6, 0);
    do_one(3, 255, 0, 1);
    do_one(3, 0, 0, 0);

    // Round robin 0,1,2,3,0 then req=1001 -> 0 already taken, then 3
    for (int i = 0; i < int'(REQS); i++) begin
      op_a[i] = int'($urandom_range(0, 255));
      op_b[i] = int'($urandom_range(0, 255));
      op_c[i] = int'($urandom_range(0, 1));
    end
    drive_ops();
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0); push_exp(3);
    req = 4'b1111;
    wait_gnt("rr_g0", 4'b0001);
    wait_gnt("rr_g1", 4'b0010);
    wait_gnt("rr_g2", 4'b0100);
    wait_gnt("rr_g3", 4'b1000);
    req = 4'b1001;
    wait_gnt("rr_g0b", 4'b0001);
    wait_gnt("rr_g3b", 4'b1000);
    req = '0;
    tick();
    wait_idle("rr_idle");

    // Backpressure with a pending request from requester 2
    rsp_ready = 1'b0;
    op_a[1] = 100; op_b[1] = 200; op_c[1] = 1;
    op_a[2] = 17;  op_b[2] = 9;   op_c[2] = 0;
    drive_ops();
    push_exp(1);
    req = 4'b0010;
    wait_gnt("bp_gnt1", 4'b0010);
    req = 4'b0100;
    push_exp(2);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_nognt", 32'(gnt), 32'd0);
      check("bp_sum", 32'(rsp_sum), 32'd45);
      check("bp_cout", 32'(rsp_cout), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    wait_gnt("bp_gnt2", 4'b0100);
    req = '0;
    tick();
    wait_idle("bp_idle");

    // Operand isolation: operands change right after the grant
    op_a[0] = 10; op_b[0] = 20; op_c[0] = 1;
    drive_ops();
    push_exp(0);
    req = 4'b0001;
    wait_gnt("iso_gnt", 4'b0001);
    req = '0;
    op_a[0] = 200; op_b[0] = 99; op_c[0] = 0;
    drive_ops();
    tick();
    wait_idle("iso_idle");

    // Reset during COMPUTE discards the result and clears rr_ptr
    op_a[3] = 77; op_b[3] = 3; op_c[3] = 0;
    drive_ops();
    req = 4'b1000;
    wait_gnt("rst_mid_gnt", 4'b1000);
    reset = 1'b1;
    req = 4'b1001;
    tick();
    check("rmid_gnt", 32'(gnt), 32'd0);
    check("rmid_valid", 32'(rsp_valid), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    op_a[0] = 128; op_b[0] = 128; op_c[0] = 1;
    drive_ops();
    push_exp(0); push_exp(3);
    reset = 1'b0;
    wait_gnt("rmid_first0", 4'b0001);
    wait_gnt("rmid_then3", 4'b1000);
    req = '0;
    tick();
    wait_idle("rmid_idle");
    repeat (3) tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
